// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, syscall halt/resume,
// plus saturating stall/flush/run-cycle counters.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instruction,
  input  logic [31:0]      exe_instruction,
  input  logic             branch_taken,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_go,
  output logic             if_id_go,
  output logic             if_id_clear,
  output logic             id_exe_go,
  output logic             id_exe_clear_one,
  output logic             id_exe_clear_two,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [31:0]      cycle_count
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             halted_q;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic [31:0]      cycle_q, cycle_d;

  logic [5:0] id_op_s, id_funct_s, exe_op_s;
  logic [4:0] id_rs_s, id_rt_s, exe_rt_s;
  logic       rs_used_s, rt_used_s, load_use_s;
  logic       unused_bits_s;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [31:0] sat_inc_32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign id_op_s    = id_instruction[31:26];
  assign id_rs_s    = id_instruction[25:21];
  assign id_rt_s    = id_instruction[20:16];
  assign id_funct_s = id_instruction[5:0];
  assign exe_op_s   = exe_instruction[31:26];
  assign exe_rt_s   = exe_instruction[20:16];
  assign unused_bits_s = ^{id_instruction[15:6], exe_instruction[25:21], exe_instruction[15:0]};

  // Source-register usage of the ID instruction (jumps, lui and shifts-by-shamt skip rs)
  always_comb begin
    rs_used_s = 1'b1;
    rt_used_s = 1'b0;
    case (id_op_s)
      6'h00: begin
        rt_used_s = 1'b1;
        rs_used_s = !((id_funct_s == 6'h00) || (id_funct_s == 6'h02) || (id_funct_s == 6'h03));
      end
      6'h02, 6'h03, 6'h0f: rs_used_s = 1'b0;
      6'h04, 6'h05, 6'h2b: rt_used_s = 1'b1;
      default: begin
        rs_used_s = 1'b1;
        rt_used_s = 1'b0;
      end
    endcase
  end

  assign load_use_s = (exe_op_s == 6'h23) && (exe_rt_s != 5'd0) &&
                      ((rs_used_s && (id_rs_s == exe_rt_s)) || (rt_used_s && (id_rt_s == exe_rt_s)));

  // Same-cycle pipeline enables/clears; branch flush outranks the load-use bubble
  always_comb begin
    pc_go            = 1'b1;
    if_id_go         = 1'b1;
    if_id_clear      = 1'b0;
    id_exe_go        = 1'b1;
    id_exe_clear_one = 1'b0;
    id_exe_clear_two = 1'b0;
    if (rst) begin
      if_id_clear      = 1'b1;
      id_exe_clear_one = 1'b1;
    end else if (state_q == HALT) begin
      pc_go     = 1'b0;
      if_id_go  = 1'b0;
      id_exe_go = 1'b0;
    end else if (branch_taken) begin
      if_id_clear      = 1'b1;
      id_exe_clear_two = 1'b1;
    end else if (load_use_s) begin
      pc_go            = 1'b0;
      if_id_go         = 1'b0;
      id_exe_clear_one = 1'b1;
    end else begin
      pc_go = 1'b1;
    end
  end

  // Next-state for the run/halt state and the counters (frozen in HALT)
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    flush_d = flush_q;
    cycle_d = cycle_q;
    if (state_q == RUN) begin
      cycle_d = sat_inc_32(cycle_q);
      if (branch_taken) begin
        flush_d = sat_inc_cnt(flush_q);
      end else if (load_use_s) begin
        stall_d = sat_inc_cnt(stall_q);
      end else begin
        stall_d = stall_q;
      end
      if (halt_req) begin
        state_d = HALT;
      end else begin
        state_d = RUN;
      end
    end else begin
      if (resume) begin
        state_d = RUN;
      end else begin
        state_d = HALT;
      end
    end
  end

  // State, halted flag and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
      cycle_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALT);
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      cycle_q  <= cycle_d;
    end
  end

  assign halted      = halted_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a default-width instance plus a CNT_W=2
// instance sharing the same stimulus for counter saturation.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instruction, exe_instruction;
  logic        branch_taken, halt_req, resume;

  logic        pc_go, if_id_go, if_id_clear, id_exe_go, id_exe_clear_one, id_exe_clear_two, halted;
  logic [15:0] stall_count, flush_count;
  logic [31:0] cycle_count;

  logic        s_pc_go, s_if_id_go, s_if_id_clear, s_id_exe_go, s_clr1, s_clr2, s_halted;
  logic [1:0]  s_stall, s_flush;
  logic [31:0] s_cycle;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] LW8    = 32'h8C08_0000;
  localparam logic [31:0] LW0    = 32'h8C00_0000;
  localparam logic [31:0] ADD989 = 32'h0109_4820;

  typedef struct packed {
    logic        r;
    logic [31:0] id;
    logic [31:0] exe;
    logic        br;
    logic        hr;
    logic        res;
    logic        lu;
  } vec_t;

  typedef logic [70:0] obs_t;

  obs_t       obs_s;
  obs_t       sb_q[$];
  obs_t       exp_v;
  int         checks = 0;
  int         errors = 0;

  logic        m_halt;
  logic [15:0] m_stall, m_flush;
  logic [31:0] m_cycle;
  logic [1:0]  m_sat_stall;
  vec_t        pend;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_instruction(id_instruction), .exe_instruction(exe_instruction),
    .branch_taken(branch_taken), .halt_req(halt_req), .resume(resume),
    .pc_go(pc_go), .if_id_go(if_id_go), .if_id_clear(if_id_clear), .id_exe_go(id_exe_go),
    .id_exe_clear_one(id_exe_clear_one), .id_exe_clear_two(id_exe_clear_two), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count), .cycle_count(cycle_count)
  );

  pipeline_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_instruction(id_instruction), .exe_instruction(exe_instruction),
    .branch_taken(branch_taken), .halt_req(halt_req), .resume(resume),
    .pc_go(s_pc_go), .if_id_go(s_if_id_go), .if_id_clear(s_if_id_clear), .id_exe_go(s_id_exe_go),
    .id_exe_clear_one(s_clr1), .id_exe_clear_two(s_clr2), .halted(s_halted),
    .stall_count(s_stall), .flush_count(s_flush), .cycle_count(s_cycle)
  );

  always #5 clk = ~clk;

  assign obs_s = {pc_go, if_id_go, if_id_clear, id_exe_go, id_exe_clear_one, id_exe_clear_two,
                  halted, stall_count, flush_count, cycle_count};

  // Apply one vector and push the expected observation for this cycle
  task automatic drive(input vec_t v);
    logic [5:0] c;
    rst = v.r; id_instruction = v.id; exe_instruction = v.exe;
    branch_taken = v.br; halt_req = v.hr; resume = v.res;
    if (v.r)         c = 6'b111110;
    else if (m_halt) c = 6'b000000;
    else if (v.br)   c = 6'b111101;
    else if (v.lu)   c = 6'b000110;
    else             c = 6'b110100;
    sb_q.push_back({c, m_halt, m_stall, m_flush, m_cycle});
    pend = v;
  endtask

  // Clock edge, then update the reference model from the pending vector
  task automatic advance();
    @(posedge clk);
    if (pend.r) begin
      m_halt = 1'b0; m_stall = 16'd0; m_flush = 16'd0; m_cycle = 32'd0; m_sat_stall = 2'd0;
    end else if (!m_halt) begin
      if (m_cycle != 32'hFFFF_FFFF) m_cycle = m_cycle + 32'd1;
      if (pend.br) begin
        if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
      end else if (pend.lu) begin
        if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (m_sat_stall != 2'd3) m_sat_stall = m_sat_stall + 2'd1;
      end
      if (pend.hr) m_halt = 1'b1;
    end else if (pend.res) begin
      m_halt = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    vec_t v[3];
    v[0] = '{1'b1, ADD989, LW8, 1'b1, 1'b0, 1'b0, 1'b1};
    v[1] = '{1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0};
    v[2] = '{1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0};
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs_s !== exp_v) begin
        errors++;
        $display("FAIL reset[%0d]: got %h expected %h", i, obs_s, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    vec_t v[9];
    v[0] = '{1'b0, ADD989,       LW8,    1'b0, 1'b0, 1'b0, 1'b1};
    v[1] = '{1'b0, NOP,          NOP,    1'b0, 1'b0, 1'b0, 1'b0};
    v[2] = '{1'b0, 32'h0008_4880, LW8,   1'b0, 1'b0, 1'b0, 1'b1};
    v[3] = '{1'b0, 32'hAD28_0000, LW8,   1'b0, 1'b0, 1'b0, 1'b1};
    v[4] = '{1'b0, 32'h2108_0001, LW8,   1'b0, 1'b0, 1'b0, 1'b1};
    v[5] = '{1'b0, 32'h1100_0000, LW8,   1'b0, 1'b0, 1'b0, 1'b1};
    v[6] = '{1'b0, 32'h0100_0008, LW8,   1'b0, 1'b0, 1'b0, 1'b1};
    v[7] = '{1'b0, ADD989,       ADD989, 1'b0, 1'b0, 1'b0, 1'b0};
    v[8] = '{1'b0, NOP,          NOP,    1'b0, 1'b0, 1'b0, 1'b0};
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs_s !== exp_v) begin
        errors++;
        $display("FAIL load_use[%0d]: got %h expected %h", i, obs_s, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_no_hazard();
    vec_t v[5];
    v[0] = '{1'b0, 32'h0000_4820, LW0, 1'b0, 1'b0, 1'b0, 1'b0};
    v[1] = '{1'b0, 32'h3C08_0001, LW8, 1'b0, 1'b0, 1'b0, 1'b0};
    v[2] = '{1'b0, 32'h2008_0001, LW8, 1'b0, 1'b0, 1'b0, 1'b0};
    v[3] = '{1'b0, 32'h0800_0008, LW8, 1'b0, 1'b0, 1'b0, 1'b0};
    v[4] = '{1'b0, NOP,           NOP, 1'b0, 1'b0, 1'b0, 1'b0};
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs_s !== exp_v) begin
        errors++;
        $display("FAIL no_hazard[%0d]: got %h expected %h", i, obs_s, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_branch();
    vec_t v[4];
    v[0] = '{1'b0, ADD989, LW8, 1'b1, 1'b0, 1'b0, 1'b1};
    v[1] = '{1'b0, NOP,    NOP, 1'b1, 1'b0, 1'b0, 1'b0};
    v[2] = '{1'b0, ADD989, LW8, 1'b0, 1'b0, 1'b0, 1'b1};
    v[3] = '{1'b0, NOP,    NOP, 1'b0, 1'b0, 1'b0, 1'b0};
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs_s !== exp_v) begin
        errors++;
        $display("FAIL branch[%0d]: got %h expected %h", i, obs_s, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_halt_resume();
    vec_t v[8];
    v[0] = '{1'b0, NOP,    NOP, 1'b0, 1'b1, 1'b0, 1'b0};
    v[1] = '{1'b0, NOP,    NOP, 1'b0, 1'b0, 1'b0, 1'b0};
    v[2] = '{1'b0, ADD989, LW8, 1'b1, 1'b1, 1'b0, 1'b1};
    v[3] = '{1'b0, NOP,    NOP, 1'b0, 1'b0, 1'b1, 1'b0};
    v[4] = '{1'b0, NOP,    NOP, 1'b0, 1'b0, 1'b0, 1'b0};
    v[5] = '{1'b0, NOP,    NOP, 1'b0, 1'b0, 1'b1, 1'b0};
    v[6] = '{1'b0, ADD989, LW8, 1'b0, 1'b0, 1'b1, 1'b1};
    v[7] = '{1'b0, NOP,    NOP, 1'b0, 1'b0, 1'b0, 1'b0};
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs_s !== exp_v) begin
        errors++;
        $display("FAIL halt_resume[%0d]: got %h expected %h", i, obs_s, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    vec_t v[7];
    v[0] = '{1'b1, NOP,    NOP, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 1; i <= 5; i++) v[i] = '{1'b0, ADD989, LW8, 1'b0, 1'b0, 1'b0, 1'b1};
    v[6] = '{1'b0, NOP,    NOP, 1'b0, 1'b0, 1'b0, 1'b0};
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs_s !== exp_v) begin
        errors++;
        $display("FAIL saturation[%0d]: got %h expected %h", i, obs_s, exp_v);
      end
      if (i > 0) begin
        checks++;
        if (s_stall !== m_sat_stall) begin
          errors++;
          $display("FAIL sat_stall[%0d]: got %0d expected %0d", i, s_stall, m_sat_stall);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_in_halt();
    vec_t v[5];
    v[0] = '{1'b0, NOP,    NOP, 1'b1, 1'b1, 1'b0, 1'b0};
    v[1] = '{1'b0, NOP,    NOP, 1'b0, 1'b0, 1'b0, 1'b0};
    v[2] = '{1'b1, ADD989, LW8, 1'b1, 1'b0, 1'b0, 1'b1};
    v[3] = '{1'b0, NOP,    NOP, 1'b0, 1'b0, 1'b0, 1'b0};
    v[4] = '{1'b0, NOP,    NOP, 1'b0, 1'b0, 1'b0, 1'b0};
    foreach (v[i]) begin
      drive(v[i]);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (obs_s !== exp_v) begin
        errors++;
        $display("FAIL reset_in_halt[%0d]: got %h expected %h", i, obs_s, exp_v);
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; id_instruction = NOP; exe_instruction = NOP;
    branch_taken = 1'b0; halt_req = 1'b0; resume = 1'b0;
    m_halt = 1'b0; m_stall = 16'd0; m_flush = 16'd0; m_cycle = 32'd0; m_sat_stall = 2'd0;
    pend = '0;
    pend.r = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_halt_resume();
    test_saturation();
    test_reset_in_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
